mux_scanner: RTL

MUX_SCANNER -- requirements
Module: mux_scanner

---
 rtl/mux_scanner.sv | 96 +++++++++
 1 files changed

// File: rtl/mux_scanner.sv
// Scans the enabled channels of a 16:1 mux in ascending order.
// Each enabled channel is sampled once and handed downstream through a valid/ready handshake.
module mux_scanner #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   mask,
  output logic [3:0]    sel,
  output logic          sel_en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [3:0]    dout_ch,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, SEL, OUT, FIN} state_t;

  state_t      state, state_nxt;
  logic [15:0] mask_r;
  logic [15:0] above;
  logic [3:0]  ch, ch_nxt;
  logic        load_mask;

  function automatic logic [3:0] lowest_set(input logic [15:0] m);
    lowest_set = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) lowest_set = 4'(i);
    end
  endfunction

  // Candidates left in the scan: latched enables strictly above the current channel.
  assign above = mask_r & (16'hFFFF << (5'(ch) + 5'd1));

  always_comb begin
    state_nxt = state;
    ch_nxt    = ch;
    load_mask = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_mask = 1'b1;
          if (|mask) begin
            state_nxt = SEL;
            ch_nxt    = lowest_set(mask);
          end else begin
            state_nxt = FIN;
          end
        end
      end
      SEL: state_nxt = OUT;
      OUT: begin
        if (dout_ready) begin
          if (|above) begin
            state_nxt = SEL;
            ch_nxt    = lowest_set(above);
          end else begin
            state_nxt = FIN;
          end
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ch      <= 4'd0;
      mask_r  <= 16'd0;
      dout    <= '0;
      dout_ch <= 4'd0;
    end else begin
      state <= state_nxt;
      ch    <= ch_nxt;
      if (load_mask) mask_r <= mask;
      if (state == SEL) begin
        dout    <= din;
        dout_ch <= ch;
      end
    end
  end

  // ch only moves on entry to SEL, so it doubles as the held mux select.
  assign sel        = ch;
  assign sel_en     = (state == SEL);
  assign dout_valid = (state == OUT);
  assign busy       = (state != IDLE);
  assign done       = (state == FIN);

endmodule
